load_unit: RTL and testbench
============================

// Module: load_unit
// PURPOSE
//  Read-side counterpart of the STRV32I store path. Accepts LB/LH/LW/LBU/LHU requests
//  from execute, issues one data-memory read, waits a variable number of cycles for the
//  response, then aligns, sign/zero-extends and registers the result for writeback.
//  Holds the pipeline (stall) while a read is outstanding; detects misalignment and timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in WAIT before aborting with lu_err_out (>=2)
//  CNT_W           5   width of wait counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk_in              in   1   single clock, rising edge
//  rst_n_in            in   1   asynchronous, active-low reset
//  mem_rd_req_in       in   1   load request from execute (valid this cycle)
//  funct3_in           in   3   000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
//  iadder_in           in   32  effective byte address
//  flush_in            in   1   pipeline flush; abandons outstanding load
//  dm_rd_valid_in      in   1   memory read data valid
//  dm_data_in          in   32  memory read data (word containing address)
//  dm_addr_out         out  32  word-aligned read address {addr[31:2],2'b00}
//  dm_rd_req_out       out  1   read strobe, held high for whole WAIT
//  lu_output_out       out  32  aligned/extended load result
//  lu_valid_out        out  1   one-cycle pulse: lu_output_out valid
//  lu_stall_out        out  1   high while a load is outstanding
//  lu_misalign_out     out  1   one-cycle pulse: misaligned or illegal-funct3 request
//  lu_err_out          out  1   one-cycle pulse: memory timeout
// BEHAVIOUR
//  Reset (async, rst_n_in=0): state IDLE, counter 0, all outputs 0, captured regs 0.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: on mem_rd_req_in & legal & aligned: latch funct3, addr[1:0], addr; -> WAIT.
//     misaligned (LH/LHU addr[0]=1, LW addr[1:0]!=0) or illegal funct3: pulse
//     lu_misalign_out next cycle, no memory request, stay IDLE.
//   WAIT: dm_rd_req_out=1, lu_stall_out=1, counter increments each cycle.
//     dm_rd_valid_in=1: register aligned data -> RESP (earliest: data 2 cycles after req).
//     counter==TIMEOUT_CYCLES-1 without valid: pulse lu_err_out, -> IDLE.
//   RESP: lu_valid_out=1 for exactly one cycle, lu_stall_out=0, -> IDLE.
//  Requests arriving in WAIT are ignored (execute is stalled); in RESP a new legal request
//   is accepted directly (RESP -> WAIT) for back-to-back loads.
//  flush_in: highest priority; any state -> IDLE next cycle, counter cleared, no valid/err
//   pulse; a dm_rd_valid_in in the same cycle is discarded.
//  dm_rd_valid_in in IDLE/RESP: ignored.
//  Alignment (off = latched addr[1:0]): byte b = dm_data_in[8*off+7 : 8*off];
//   half h = off[1] ? dm_data_in[31:16] : dm_data_in[15:0]; word = dm_data_in.
//   funct3[2]=0 sign-extends b/h to 32 bits, =1 zero-extends.
//  lu_output_out holds last value until next valid load; cleared only by reset.
// STRUCTURE
//  Shared package: funct3 load encodings, FSM state enum (IDLE/WAIT/RESP), data width 32.
//  One sub-module natural: load_align (combinational extract + extend, reusable in tests).
//  FSM, counter, capture registers stay in load_unit.
// TESTING
//  LB addr 0x103, data 0x80FF_1234 returned after 3 wait cycles -> lu_output 0xFFFF_FF80,
//   lu_valid one cycle, stall high 3 cycles.
//  LHU addr 0x102, data 0x8001_5555 -> 0x0000_8001; LH same -> 0xFFFF_8001.
//  LW addr 0x101 -> lu_misalign pulse, dm_rd_req_out never asserted, no stall.
//  LW, no dm_rd_valid for TIMEOUT_CYCLES -> lu_err pulse, return to IDLE, no lu_valid.
//  flush_in asserted in WAIT coincident with dm_rd_valid -> no lu_valid, IDLE next cycle.
//  rst_n_in low mid-WAIT (async, between edges) -> all outputs 0 immediately.

Source files
------------

// File: rtl/load_unit_pkg.sv
// load_unit_pkg: shared definitions for the load unit.
//   DATA_W          data path width
//   F3_*            funct3 encodings of the supported loads
//   lu_state_t      load unit FSM states
//   load_ok()       1 when a funct3/address-offset pair is a legal, aligned load
package load_unit_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lu_state_t;

  function automatic logic load_ok(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_LB, F3_LBU: return 1'b1;
      F3_LH, F3_LHU: return ~lo[0];
      F3_LW:         return (lo == 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_unit_align.sv
// load_align: combinational byte/half/word extract and sign/zero extension.
//   funct3  in   load type (legal encodings only)
//   off     in   byte offset within the word
//   data    in   memory word containing the addressed bytes
//   result  out  aligned, extended load value
module load_align
  import load_unit_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sext;

  always_comb begin
    case (off)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h    = off[1] ? data[31:16] : data[15:0];
    // funct3[2] set selects the unsigned variants
    sext = ~funct3[2];
    case (funct3[1:0])
      2'b00:   result = {{24{sext & b[7]}}, b};
      2'b01:   result = {{16{sext & h[15]}}, h};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// load_unit: issues one data-memory read per load, waits for the response,
// aligns/extends it and presents it for writeback. Stalls while a read is
// outstanding and flags misaligned/illegal requests and memory timeouts.
//   clk_in / rst_n_in      clock, async active-low reset
//   mem_rd_req_in, funct3_in, iadder_in, flush_in   request side from execute
//   dm_rd_valid_in, dm_data_in                      memory response
//   dm_addr_out, dm_rd_req_out                      memory request
//   lu_output_out, lu_valid_out, lu_stall_out,
//   lu_misalign_out, lu_err_out                     results / status to pipeline
//
// state   | meaning
// IDLE    | no load outstanding
// WAIT    | read issued, waiting for dm_rd_valid_in (bounded by TIMEOUT_CYCLES)
// RESP    | result registered, lu_valid_out high for this one cycle
module load_unit
  import load_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              mem_rd_req_in,
  input  logic [2:0]        funct3_in,
  input  logic [31:0]       iadder_in,
  input  logic              flush_in,
  input  logic              dm_rd_valid_in,
  input  logic [31:0]       dm_data_in,
  output logic [31:0]       dm_addr_out,
  output logic              dm_rd_req_out,
  output logic [DATA_W-1:0] lu_output_out,
  output logic              lu_valid_out,
  output logic              lu_stall_out,
  output logic              lu_misalign_out,
  output logic              lu_err_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lu_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] aligned;

  logic req_ok, req_bad, timeout;
  logic accept, capture, err_set, mis_set;

  assign req_ok  = mem_rd_req_in & load_ok(funct3_in, iadder_in[1:0]);
  assign req_bad = mem_rd_req_in & ~req_ok;
  assign timeout = (state_q == ST_WAIT) & ~dm_rd_valid_in & (cnt_q == CNT_LAST);

  load_align u_align (
    .funct3 (f3_q),
    .off    (addr_q[1:0]),
    .data   (dm_data_in),
    .result (aligned)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_in) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (req_ok) state_d = ST_WAIT;
        ST_WAIT: begin
          if (dm_rd_valid_in) state_d = ST_RESP;
          else if (timeout)   state_d = ST_IDLE;
        end
        ST_RESP: state_d = req_ok ? ST_WAIT : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dm_rd_req_out = (state_q == ST_WAIT);
    lu_stall_out  = (state_q == ST_WAIT);
    lu_valid_out  = (state_q == ST_RESP);
    // execute is stalled during WAIT, so requests there are not new loads
    accept        = ~flush_in & (state_q != ST_WAIT) & req_ok;
    mis_set       = ~flush_in & (state_q != ST_WAIT) & req_bad;
    capture       = ~flush_in & (state_q == ST_WAIT) & dm_rd_valid_in;
    err_set       = ~flush_in & timeout;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q           <= '0;
      f3_q            <= '0;
      addr_q          <= '0;
      lu_output_out   <= '0;
      lu_err_out      <= 1'b0;
      lu_misalign_out <= 1'b0;
    end else begin
      // counter only runs while staying in WAIT; any entry into WAIT sees 0
      if (state_q == ST_WAIT && state_d == ST_WAIT) cnt_q <= cnt_q + 1'b1;
      else                                          cnt_q <= '0;
      if (accept) begin
        f3_q   <= funct3_in;
        addr_q <= iadder_in;
      end
      if (capture) lu_output_out <= aligned;
      lu_err_out      <= err_set;
      lu_misalign_out <= mis_set;
    end
  end

  assign dm_addr_out = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rd_req = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] iadder = 32'h0;
  logic        flush = 1'b0;
  logic        dm_rd_valid = 1'b0;
  logic [31:0] dm_data = 32'h0;
  logic [31:0] dm_addr_out;
  logic        dm_rd_req_out;
  logic [31:0] lu_output_out;
  logic        lu_valid_out, lu_stall_out, lu_misalign_out, lu_err_out;

  int n_cmp = 0;
  int n_bad = 0;
  int vld_cnt = 0, stall_cnt = 0, req_cnt = 0, err_cnt = 0, mis_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  load_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .mem_rd_req_in   (mem_rd_req),
    .funct3_in       (funct3),
    .iadder_in       (iadder),
    .flush_in        (flush),
    .dm_rd_valid_in  (dm_rd_valid),
    .dm_data_in      (dm_data),
    .dm_addr_out     (dm_addr_out),
    .dm_rd_req_out   (dm_rd_req_out),
    .lu_output_out   (lu_output_out),
    .lu_valid_out    (lu_valid_out),
    .lu_stall_out    (lu_stall_out),
    .lu_misalign_out (lu_misalign_out),
    .lu_err_out      (lu_err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> (8 * a[1:0]);
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b010:  return d;
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  // scoreboard / event monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (lu_valid_out) begin
        vld_cnt++;
        if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else                   chk("lu_output", lu_output_out, exp_q.pop_front());
      end
      if (lu_stall_out)    stall_cnt++;
      if (dm_rd_req_out)   req_cnt++;
      if (lu_err_out)      err_cnt++;
      if (lu_misalign_out) mis_cnt++;
    end
  end

  // lat = number of WAIT cycles; data valid in the last of them
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input int lat, input bit b2b);
    if (!b2b) @(negedge clk);
    mem_rd_req = 1'b1; funct3 = f3; iadder = addr;
    last_exp = model(f3, addr, data);
    exp_q.push_back(last_exp);
    @(negedge clk);
    mem_rd_req = 1'b0;
    chk("dm_addr", dm_addr_out, {addr[31:2], 2'b00});
    chk("dm_rd_req", {31'b0, dm_rd_req_out}, 32'd1);
    for (int i = 1; i < lat; i++) @(negedge clk);
    dm_rd_valid = 1'b1; dm_data = data;
    @(negedge clk);
    dm_rd_valid = 1'b0; dm_data = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int v0, s0, r0, e0, m0;
    logic [2:0] f3;
    logic [31:0] a;
    logic [2:0]  mis_f3[4]   = '{3'b010, 3'b001, 3'b011, 3'b101};
    logic [31:0] mis_addr[4] = '{32'h101, 32'h201, 32'h0, 32'h3};
    logic [2:0]  legal[5]    = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    #12;
    chk("rst_dm_req", {31'b0, dm_rd_req_out}, 32'd0);
    chk("rst_stall", {31'b0, lu_stall_out}, 32'd0);
    chk("rst_valid", {31'b0, lu_valid_out}, 32'd0);
    chk("rst_output", lu_output_out, 32'd0);
    chk("rst_addr", dm_addr_out, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    // LB with 3 wait cycles
    v0 = vld_cnt; s0 = stall_cnt;
    do_load(3'b000, 32'h103, 32'h80FF_1234, 3, 1'b0);
    idle(3);
    chk("lb_valid_cnt", vld_cnt - v0, 1);
    chk("lb_stall_cycles", stall_cnt - s0, 3);
    chk("lb_hold", lu_output_out, 32'hFFFF_FF80);

    do_load(3'b101, 32'h102, 32'h8001_5555, 2, 1'b0);
    idle(2);
    chk("lhu_hold", lu_output_out, 32'h0000_8001);
    do_load(3'b001, 32'h102, 32'h8001_5555, 2, 1'b0);
    idle(2);
    chk("lh_hold", lu_output_out, 32'hFFFF_8001);

    // misaligned / illegal requests
    for (int k = 0; k < 4; k++) begin
      r0 = req_cnt; s0 = stall_cnt; m0 = mis_cnt;
      @(negedge clk);
      mem_rd_req = 1'b1; funct3 = mis_f3[k]; iadder = mis_addr[k];
      @(negedge clk);
      mem_rd_req = 1'b0;
      chk("misalign_pulse", {31'b0, lu_misalign_out}, 32'd1);
      @(negedge clk);
      chk("misalign_drop", {31'b0, lu_misalign_out}, 32'd0);
      idle(2);
      chk("misalign_no_req", req_cnt - r0, 0);
      chk("misalign_no_stall", stall_cnt - s0, 0);
      chk("misalign_cnt", mis_cnt - m0, 1);
    end

    // timeout
    v0 = vld_cnt; s0 = stall_cnt; e0 = err_cnt;
    @(negedge clk);
    mem_rd_req = 1'b1; funct3 = 3'b010; iadder = 32'h200;
    for (int i = 1; i <= TO + 3; i++) begin
      @(negedge clk);
      mem_rd_req = 1'b0;
      if (i == TO) chk("to_stall_last", {31'b0, lu_stall_out}, 32'd1);
      if (i == TO + 1) begin
        chk("to_err_pulse", {31'b0, lu_err_out}, 32'd1);
        chk("to_idle", {31'b0, lu_stall_out}, 32'd0);
      end
    end
    chk("to_err_cnt", err_cnt - e0, 1);
    chk("to_stall_cycles", stall_cnt - s0, TO);
    chk("to_no_valid", vld_cnt - v0, 0);

    // flush coincident with data valid
    v0 = vld_cnt; e0 = err_cnt;
    @(negedge clk);
    mem_rd_req = 1'b1; funct3 = 3'b000; iadder = 32'h40;
    @(negedge clk);
    mem_rd_req = 1'b0;
    @(negedge clk);
    flush = 1'b1; dm_rd_valid = 1'b1; dm_data = 32'h1234_5678;
    @(negedge clk);
    flush = 1'b0; dm_rd_valid = 1'b0;
    chk("flush_idle_stall", {31'b0, lu_stall_out}, 32'd0);
    chk("flush_idle_req", {31'b0, dm_rd_req_out}, 32'd0);
    idle(4);
    chk("flush_no_valid", vld_cnt - v0, 0);
    chk("flush_no_err", err_cnt - e0, 0);
    chk("flush_output_kept", lu_output_out, 32'hFFFF_8001);

    // back-to-back loads, the second issued in RESP
    v0 = vld_cnt;
    do_load(3'b100, 32'h301, 32'hA5C3_7E11, 2, 1'b0);
    do_load(3'b010, 32'h304, 32'hDEAD_BEEF, 3, 1'b1);
    idle(3);
    chk("b2b_valid_cnt", vld_cnt - v0, 2);

    // random legal aligned loads
    for (int k = 0; k < 10; k++) begin
      f3 = legal[$urandom_range(0, 4)];
      a  = $urandom;
      if (f3[1:0] == 2'b10)      a[1:0] = 2'b00;
      else if (f3[1:0] == 2'b01) a[0] = 1'b0;
      do_load(f3, a, $urandom, $urandom_range(2, 5), 1'b0);
    end
    idle(3);
    chk("queue_drained", exp_q.size(), 0);

    // async reset mid-WAIT
    do_load(3'b010, 32'h500, 32'hCAFE_F00D, 2, 1'b0);
    idle(2);
    @(negedge clk);
    mem_rd_req = 1'b1; funct3 = 3'b010; iadder = 32'h604;
    @(negedge clk);
    mem_rd_req = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dm_req", {31'b0, dm_rd_req_out}, 32'd0);
    chk("arst_stall", {31'b0, lu_stall_out}, 32'd0);
    chk("arst_output", lu_output_out, 32'd0);
    chk("arst_addr", dm_addr_out, 32'd0);
    chk("arst_valid", {31'b0, lu_valid_out}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(3);
    chk("arst_stays_idle", {31'b0, lu_stall_out}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
